alu_arbiter: RTL
================

# alu_arbiter

Shares one instance of the team's combinational `ALU` between two requesters (e.g. main datapath and a coprocessor/debug port), with valid/ready handshakes on both request and response sides. It arbitrates round-robin and registers the selected operands in front of the ALU. Multiply (`ALUControl` = 101) is treated as a multi-cycle operation. Results are registered and held until the owning requester accepts them. One operation is in flight at a time.

## Interface
- `N_bit`, 32, operand/result width; passed to the internal `ALU`.
- `MUL_CYCLES`, 3, EXEC cycles spent on a multiply (≥1); all other ops take 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  grant; the op is accepted in a cycle where valid && ready.
- `req0_ctrl` / `req1_ctrl`  in  3  ALUControl code for the op.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  N_bit  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the result.
- `rsp_result`  out  N_bit  registered ALU result (shared by both response channels).
- `rsp_zero`  out  1  registered ALU Zero flag.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine: IDLE → EXEC → RESP → IDLE.
- **IDLE**
  - `reqN_ready` is combinational: at most one is high, and only in IDLE.
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester other than `last_grant` is granted.
  - On the handshake: latch ctrl, a and b into operand registers; record `owner`; set `last_grant` = owner; load `cnt` = MUL_CYCLES-1 if ctrl = 101, else 0; go to EXEC.
- **EXEC**
  - The ALU is driven only from the operand registers, never directly from request ports.
  - If `cnt` ≠ 0: decrement `cnt` and stay in EXEC.
  - If `cnt` = 0: capture ALUResult → `rsp_result` and Zero → `rsp_zero`, then go to RESP.
- **RESP**
  - `rsp<owner>_valid` = 1; the other `rspN_valid` = 0.
  - `rsp_result` and `rsp_zero` hold stable.
  - When `rsp<owner>_ready` = 1, go to IDLE in the next cycle.
  - `rspN_ready` of the non-owner is ignored.
- Arithmetic is entirely the ALU's:
  - add, sub and mult wrap modulo 2^N_bit.
  - slt (110) is unsigned.
  - Undefined codes (011, 111) complete normally in 1 EXEC cycle with result 0 and zero 1.
- A new request is not accepted in the same cycle as the response handshake; the earliest next grant is in the following IDLE cycle.
- Request inputs may change freely outside the handshake cycle; latched operands are unaffected.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1 (so req0 wins the first tie), `cnt` = 0, operand regs = 0.
  - `rsp_result` = 0, `rsp_zero` = 1.
  - All `rspN_valid` = 0, `busy` = 0.
  - Both `reqN_ready` = 0 while `rst` is high.
- Latency, with the handshake at cycle T:
  - Non-mult op: `rsp_valid` rises at T+2.
  - Mult: `rsp_valid` rises at T+1+MUL_CYCLES.
- Throughput: with `rsp_ready` tied high, a non-mult op is accepted every 3 cycles at best.
- `rsp_valid` stays high until the handshake, for any number of cycles.
- Reset asserted mid-EXEC or mid-RESP:
  - Immediately (asynchronously) return to IDLE and drop `rsp_valid`.
  - The in-flight result is discarded; no response is ever issued for it.
- A `reqN_valid` deasserted before grant causes no state change (no lost or phantom ops).

## Test plan
- **Reset/idle:** hold `rst` with random inputs → all `rspN_valid` = 0, `reqN_ready` = 0, `rsp_result` = 0, `rsp_zero` = 1, `busy` = 0.
- **Single add:** req0 sends ctrl = 010, a = 5, b = 7 at T → `req0_ready` high at T; `rsp0_valid` = 1 at T+2 with result 12 and zero 0; `rsp1_valid` stays 0.
- **Multiply latency** (MUL_CYCLES = 3): req1 sends ctrl = 101, a = 0x10000, b = 0x10000 → `rsp1_valid` rises at T+4 with result 0 (wrap) and zero 1.
- **Tie/round-robin:** both requesters hold valid continuously with sub 9-4 on req0 and or 0xF0|0x0F on req1, `rsp_ready` tied high.
  - Grants alternate req0, req1, req0 …
  - Results are 5 and 0xFF on the matching `rspN` channel.
- **Backpressure:** `rsp0_ready` = 0 for 10 cycles after `rsp0_valid` with slt 3<8.
  - `rsp_result` = 1 is held stable the whole time.
  - `req1` stays unready throughout.
  - req1 is granted one cycle after the handshake.
- **Reset mid-op:** assert `rst` during EXEC of a multiply → `busy` = 0 immediately; no `rsp_valid` after release; the next op (and 0xFF & 0x0F) returns result 0x0F normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared ALU arbiter.
// The master side drives both requesters' operations and response acks;
// the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int N_bit = 32
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_ctrl;
    logic [N_bit-1:0] req0_a;
    logic [N_bit-1:0] req0_b;

    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_ctrl;
    logic [N_bit-1:0] req1_a;
    logic [N_bit-1:0] req1_b;

    // responses: one valid/ready pair per requester, shared result bus
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [N_bit-1:0] rsp_result;
    logic             rsp_zero;

    logic             busy;

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        output rsp0_ready, rsp1_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        input  rsp0_ready, rsp1_ready,
        output busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// One operation in flight; operands are registered ahead of the ALU, the
// result is registered and held until the owning requester accepts it.
// Multiply spends MUL_CYCLES cycles in EXEC, everything else one.

// Combinational ALU.
// 000 and, 001 or, 010 add, 100 sub, 101 mul, 110 unsigned slt,
// anything else yields 0. Arithmetic wraps modulo 2^N_bit.
module ALU #(
    parameter int N_bit = 32
) (
    input  logic [2:0]       ALUControl,
    input  logic [N_bit-1:0] A,
    input  logic [N_bit-1:0] B,
    output logic [N_bit-1:0] ALUResult,
    output logic             Zero
);
    // operation decode
    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            3'b000:  ALUResult = A & B;
            3'b001:  ALUResult = A | B;
            3'b010:  ALUResult = A + B;
            3'b100:  ALUResult = A - B;
            3'b101:  ALUResult = A * B;
            3'b110:  ALUResult = {{(N_bit-1){1'b0}}, (A < B)};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);
endmodule

module alu_arbiter #(
    parameter int N_bit      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int             CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0]  MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [2:0]     CTRL_MUL = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    logic             last_grant;   // 1 = requester 1 was granted last
    logic             owner;        // requester that owns the in-flight op
    logic [CW-1:0]    cnt;

    logic [2:0]       op_ctrl;
    logic [N_bit-1:0] op_a;
    logic [N_bit-1:0] op_b;

    logic [N_bit-1:0] result_q;
    logic             zero_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             gnt0;
    logic             gnt1;
    logic             rsp_ack;

    logic [2:0]       sel_ctrl;
    logic [N_bit-1:0] sel_a;
    logic [N_bit-1:0] sel_b;

    logic [N_bit-1:0] alu_result;
    logic             alu_zero;

    // grant decision: a sole requester wins, a tie goes to the one not granted last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
                gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // operand source for the handshake cycle, owner's ack during RESP
    always_comb begin
        sel_ctrl = gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
        sel_a    = gnt1 ? bus.req1_a    : bus.req0_a;
        sel_b    = gnt1 ? bus.req1_b    : bus.req0_b;
        rsp_ack  = owner ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // ALU only ever sees the registered operands
    ALU #(.N_bit(N_bit)) u_alu (
        .ALUControl (op_ctrl),
        .A          (op_a),
        .B          (op_b),
        .ALUResult  (alu_result),
        .Zero       (alu_zero)
    );

    // control FSM with registered operands, result and response flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cnt          <= '0;
            op_ctrl      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_ctrl    <= sel_ctrl;
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        cnt        <= (sel_ctrl == CTRL_MUL) ? MUL_LOAD : '0;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        result_q     <= alu_result;
                        zero_q       <= alu_zero;
                        rsp0_valid_q <= ~owner;
                        rsp1_valid_q <= owner;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.busy       = busy_q;
endmodule
